// File: rtl/divisor_pkg.sv
// Shared constants for the restoring divider: state encoding, default widths
// and the number of shift-subtract iterations per operation.
package divisor_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CALC = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam int DVD_W = 8;
  localparam int DEN_W = 4;
  localparam int ITER  = 8;

endpackage

// File: rtl/subtrator.sv
// Combinational compare-and-subtract step: borrow=0 means minuend >= subtrahend.
module subtrator #(
  parameter int W = 4
) (
  input  logic [W:0]   minuend,
  input  logic [W-1:0] subtrahend,
  output logic [W:0]   difference,
  output logic         borrow
);

  always_comb begin
    {borrow, difference} = {1'b0, minuend} - {2'b00, subtrahend};
  end

endmodule

// File: rtl/divisor.sv
// Multi-cycle unsigned restoring divider producing one quotient bit per clock,
// MSB first, with a divide-by-zero shortcut straight to DONE.
module divisor
  import divisor_pkg::*;
#(
  parameter int N_DVD = DVD_W,
  parameter int N_DEN = DEN_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             St,
  input  logic [N_DVD-1:0] Dividendo,
  input  logic [N_DEN-1:0] Denominador,
  output logic [N_DVD-1:0] Quociente,
  output logic [N_DEN-1:0] Resto,
  output logic             Idle,
  output logic             Done,
  output logic             Erro,
  output logic [1:0]       fsm_state
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  // Dividend shifts out of the MSB while quotient bits shift into the LSB.
  logic [N_DVD-1:0] dvd_sh;
  logic [N_DEN-1:0] den_q;
  logic [N_DEN:0]   rem;

  logic [N_DEN:0]   shifted;
  logic [N_DEN:0]   diff;
  logic             borrow;
  logic [N_DEN:0]   rem_next;
  logic [N_DVD-1:0] quo_next;
  logic             unused_rem_msb;

  // The remainder stays below the divisor after each step, so its MSB is
  // always zero before the shift and is not needed to form the next value.
  assign unused_rem_msb = rem[N_DEN];
  assign shifted        = {rem[N_DEN-1:0], dvd_sh[N_DVD-1]};

  subtrator #(.W(N_DEN)) u_sub (
    .minuend    (shifted),
    .subtrahend (den_q),
    .difference (diff),
    .borrow     (borrow)
  );

  assign rem_next = borrow ? shifted : diff;
  assign quo_next = {dvd_sh[N_DVD-2:0], ~borrow};

  // Handshake: St is a level request sampled only in IDLE; Done is a single
  // cycle strobe, and Quociente/Resto/Erro are valid from Done until the next Done.
  assign Idle      = (state == S_IDLE);
  assign Done      = (state == S_DONE);
  assign fsm_state = state;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dvd_sh    <= '0;
      den_q     <= '0;
      rem       <= '0;
      Quociente <= '0;
      Resto     <= '0;
      Erro      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (St) begin
            if (Denominador == '0) begin
              Quociente <= '1;
              Resto     <= '0;
              Erro      <= 1'b1;
              state     <= S_DONE;
            end else begin
              dvd_sh <= Dividendo;
              den_q  <= Denominador;
              rem    <= '0;
              cnt    <= '0;
              state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          dvd_sh <= quo_next;
          rem    <= rem_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            Quociente <= quo_next;
            Resto     <= rem_next[N_DEN-1:0];
            Erro      <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
